pe_operand_feeder: RTL and testbench
====================================

Name: pe_operand_feeder

Overview:
Upstream operand sequencer for the PE. It holds one ifm vector and one weight vector in two small register buffers, loaded through a write port. On start it streams element pairs, one pair per clock, onto the PE ifm_in and w_in inputs. It then drives zeros for a fixed drain window so the PE pipeline settles, and pulses done to the PE.

Parameters:
WIDTH, 8, operand width in bits; matches the PE ifm/w width
DEPTH, 32, entries per buffer; maximum vector length
AW, 5, address/length counter width; must satisfy 2^AW >= DEPTH
DRAIN_CYC, 2, zero-operand cycles after the last element before done

Ports:
clk  input  1  system clock; rising edge
rst_n  input  1  asynchronous active-low reset
ld_en  input  1  buffer write strobe
ld_sel  input  1  0 = ifm buffer, 1 = weight buffer
ld_addr  input  AW  write address
ld_data  input  WIDTH  write data
start  input  1  begin streaming; sampled in IDLE only
len  input  AW+1  element count, sampled with start
clr  input  1  synchronous abort/clear
ifm_out  output  WIDTH  to PE ifm_in
w_out  output  WIDTH  to PE w_in
op_valid  output  1  high while a real element pair is on ifm_out/w_out
busy  output  1  high from the start edge until done deasserts
pe_done  output  1  to PE done; one-cycle pulse

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; ifm_out=0, w_out=0, op_valid=0, busy=0, pe_done=0; element counter=0.
- Buffer contents are not reset. Bench must load before use.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
- Loading:
  - Write occurs on a clock edge with ld_en=1 in IDLE only.
  - ld_en while busy is ignored; buffers stay unchanged.
  - ld_addr >= DEPTH is ignored.
- IDLE:
  - Edge E0 with start=1: L = min(len, DEPTH) is latched and busy goes 1.
  - L=0: go directly to DRAIN; op_valid stays 0.
  - Otherwise: go to STREAM and register element 0.
- STREAM:
  - For k = 0..L-1, the cycle after edge E0+k carries ifm_out=ifm_buf[k], w_out=w_buf[k], op_valid=1.
  - After the edge that presents element L-1, the next edge enters DRAIN.
- DRAIN:
  - Cycles after edges E0+L .. E0+L+DRAIN_CYC-1: ifm_out=0, w_out=0, op_valid=0.
  - DRAIN_CYC=0: skip DRAIN and go straight to DONE.
- DONE:
  - Cycle after edge E0+L+DRAIN_CYC: pe_done=1, busy=1.
  - Next edge: pe_done=0, busy=0, state IDLE.
- Total: start edge to pe_done high = L+DRAIN_CYC+1 edges.
- start while busy: ignored; it is not queued.
- start and ld_en on the same IDLE edge: the write completes and streaming begins. Element 0 reflects the new write if it addresses entry 0.
- clr=1 on any edge: state IDLE; outputs zeroed; op_valid=0, busy=0, pe_done=0; no done pulse. clr has priority over start.
- Asynchronous reset mid-stream: immediate return to reset values. A later start replays from element 0 with the retained buffer contents.
- Operands pass through unchanged; no arithmetic, sign handling or width change.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs 0 immediately, before any clock edge; busy=0.
- 18-element run: load ifm_buf[k]=k+1, w_buf[k]=0x10+k, k=0..17; start with len=18, DRAIN_CYC=2 -> 18 cycles of op_valid=1 with pairs (0x01,0x10)..(0x12,0x21), then 2 zero cycles, pe_done high exactly 1 cycle 21 edges after start, then busy=0.
- Boundaries:
  - len=0 -> op_valid never high; pe_done after 3 edges.
  - len=40 -> clamped to 32 elements; pe_done after 35 edges.
- Busy protection: during the run, pulse start and ld_en (addr 0, data 0xFF) -> stream unaffected, buffer[0] still 0x01. A second start afterwards replays the identical sequence.
- Abort: clr at element 5 -> next cycle outputs 0, busy=0, no pe_done. Async rst_n low at element 10 behaves the same, and a restart streams from element 0.
- Back-to-back: start asserted the cycle after busy falls -> a new run begins with no gap beyond that one idle cycle; pe_done pulses once per run.

Source files
------------

// File: rtl/pe_operand_feeder.sv
// Operand sequencer for the PE: buffers one ifm and one weight vector,
// streams element pairs, drains with zeros and pulses done.
module pe_operand_feeder #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic             ld_sel,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             start,
    input  logic [AW:0]      len,
    input  logic             clr,
    output logic [WIDTH-1:0] ifm_out,
    output logic [WIDTH-1:0] w_out,
    output logic             op_valid,
    output logic             busy,
    output logic             pe_done
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam int DW = $clog2(DRAIN_CYC + 1) + 1;

    state_t           state, state_n;
    logic [AW:0]      idx, idx_n;
    logic [AW:0]      len_q, len_n;
    logic [DW-1:0]    dcnt, dcnt_n;
    logic [WIDTH-1:0] ifm_n, w_n;
    logic             vld_n, busy_n, done_n;
    logic             wr_en;
    logic [AW:0]      l_clamp;
    logic [WIDTH-1:0] ifm0, w0;

    logic [WIDTH-1:0] ifm_buf [DEPTH];
    logic [WIDTH-1:0] w_buf   [DEPTH];

    assign wr_en = ld_en && (state == IDLE) && (int'(ld_addr) < DEPTH);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (ld_sel) w_buf[ld_addr]   <= ld_data;
            else        ifm_buf[ld_addr] <= ld_data;
        end
    end

    assign l_clamp = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;

    // element 0 sees a write landing on the same start edge
    assign ifm0 = (wr_en && !ld_sel && ld_addr == '0) ? ld_data : ifm_buf[0];
    assign w0   = (wr_en &&  ld_sel && ld_addr == '0) ? ld_data : w_buf[0];

    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len_q;
        dcnt_n  = dcnt;
        ifm_n   = '0;
        w_n     = '0;
        vld_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    len_n = l_clamp;
                    if (l_clamp == '0) begin
                        state_n = (DRAIN_CYC == 0) ? DONE : DRAIN;
                        dcnt_n  = DW'(1);
                    end else begin
                        state_n = STREAM;
                        ifm_n   = ifm0;
                        w_n     = w0;
                        vld_n   = 1'b1;
                        idx_n   = (AW+1)'(1);
                    end
                end
            end
            STREAM: begin
                if (idx == len_q) begin
                    state_n = (DRAIN_CYC == 0) ? DONE : DRAIN;
                    dcnt_n  = DW'(1);
                end else begin
                    ifm_n = ifm_buf[idx[AW-1:0]];
                    w_n   = w_buf[idx[AW-1:0]];
                    vld_n = 1'b1;
                    idx_n = idx + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == DW'(DRAIN_CYC)) state_n = DONE;
                else                        dcnt_n  = dcnt + 1'b1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (clr) begin
            state_n = IDLE;
            idx_n   = '0;
            ifm_n   = '0;
            w_n     = '0;
            vld_n   = 1'b0;
        end
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            len_q    <= '0;
            dcnt     <= '0;
            ifm_out  <= '0;
            w_out    <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            pe_done  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            len_q    <= len_n;
            dcnt     <= dcnt_n;
            ifm_out  <= ifm_n;
            w_out    <= w_n;
            op_valid <= vld_n;
            busy     <= busy_n;
            pe_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Self-checking bench for pe_operand_feeder against a per-cycle
// reference built from buffer arrays and the run-length rules.
module tb_pe_operand_feeder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int D     = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ld_en, ld_sel, start, clr;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [AW:0]      len;
    logic [WIDTH-1:0] ifm_out, w_out;
    logic             op_valid, busy, pe_done;

    logic [WIDTH-1:0] ifm_m [DEPTH];
    logic [WIDTH-1:0] w_m   [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_operand_feeder #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .DRAIN_CYC(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .len(len), .clr(clr),
        .ifm_out(ifm_out), .w_out(w_out),
        .op_valid(op_valid), .busy(busy), .pe_done(pe_done)
    );

    // Expected {op_valid, ifm, w, busy, pe_done} after the n-th edge,
    // counting the start edge as n=1.
    function automatic logic [18:0] exp_at(input int n, input int l);
        if (n <= l)            return {1'b1, ifm_m[n-1], w_m[n-1], 1'b1, 1'b0};
        else if (n <= l + D)   return {1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        else if (n == l + D + 1) return {1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
        else                   return '0;
    endfunction

    function automatic logic [18:0] obs();
        return {op_valid, ifm_out, w_out, busy, pe_done};
    endfunction

    task automatic idle_inputs();
        ld_en = 0; ld_sel = 0; ld_addr = '0; ld_data = '0;
        start = 0; len = '0; clr = 0;
    endtask

    task automatic load(input bit sel, input int addr, input logic [7:0] d);
        ld_en = 1; ld_sel = sel; ld_addr = AW'(addr); ld_data = d;
        @(posedge clk);
        @(negedge clk);
        ld_en = 0;
        if (addr < DEPTH) begin
            if (sel) w_m[addr] = d;
            else     ifm_m[addr] = d;
        end
    endtask

    task automatic run_stream(input string nm, input int len_i, input bit inj,
                              input bit with_ld, input bit lsel,
                              input logic [7:0] ldat);
        int l;
        logic [18:0] e;
        l = (len_i > DEPTH) ? DEPTH : len_i;
        start = 1; len = (AW+1)'(len_i);
        if (with_ld) begin
            ld_en = 1; ld_sel = lsel; ld_addr = '0; ld_data = ldat;
            if (lsel) w_m[0] = ldat;
            else      ifm_m[0] = ldat;
        end
        for (int n = 1; n <= l + D + 2; n++) begin
            @(posedge clk);
            @(negedge clk);
            idle_inputs();
            e = exp_at(n, l);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL %s n=%0d got=%h exp=%h", nm, n, obs(), e);
            end
            if (inj && (n == 3 || n == 4)) begin
                start = 1; len = 6'd5;
                ld_en = 1; ld_sel = (n == 4); ld_addr = '0; ld_data = 8'hFF;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #3;
        n_cmp++;
        if (obs() !== '0) begin
            n_bad++;
            $display("FAIL reset got=%h exp=0", obs());
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_stream18();
        for (int k = 0; k < 18; k++) begin
            load(0, k, 8'(k + 1));
            load(1, k, 8'(8'h10 + k));
        end
        run_stream("stream18", 18, 0, 0, 0, 8'h00);
    endtask

    task automatic test_busy_protect();
        run_stream("busy_inj", 18, 1, 0, 0, 8'h00);
        run_stream("busy_replay", 18, 0, 0, 0, 8'h00);
    endtask

    task automatic test_len0();
        run_stream("len0", 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_start_with_load();
        run_stream("start_ld_ifm", 4, 0, 1, 0, 8'hA5);
        run_stream("start_ld_w", 3, 0, 1, 1, 8'h5A);
    endtask

    task automatic test_len40();
        for (int k = 0; k < DEPTH; k++) begin
            load(0, k, 8'($urandom));
            load(1, k, 8'($urandom));
        end
        run_stream("len40", 40, 0, 0, 0, 8'h00);
        run_stream("len32", 32, 0, 0, 0, 8'h00);
        run_stream("len1", 1, 0, 0, 0, 8'h00);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++)
            run_stream("b2b", int'($urandom_range(0, 33)), 0, 0, 0, 8'h00);
    endtask

    task automatic test_abort_clr();
        logic [18:0] e;
        start = 1; len = 6'd18;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            idle_inputs();
            e = exp_at(n, 18);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL clr_pre n=%0d got=%h exp=%h", n, obs(), e);
            end
        end
        clr = 1;
        @(posedge clk);
        @(negedge clk);
        clr = 0;
        n_cmp++;
        if (obs() !== '0) begin
            n_bad++;
            $display("FAIL clr_zero got=%h exp=0", obs());
        end
        for (int c = 0; c < 25; c++) begin
            if (c == 3) begin clr = 1; start = 1; len = 6'd4; end
            @(posedge clk);
            @(negedge clk);
            idle_inputs();
            n_cmp++;
            if (obs() !== '0) begin
                n_bad++;
                $display("FAIL clr_quiet c=%0d got=%h exp=0", c, obs());
            end
        end
    endtask

    task automatic test_abort_rst();
        logic [18:0] e;
        start = 1; len = 6'd18;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk);
            @(negedge clk);
            idle_inputs();
            e = exp_at(n, 18);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL rst_pre n=%0d got=%h exp=%h", n, obs(), e);
            end
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if (obs() !== '0) begin
            n_bad++;
            $display("FAIL rst_async got=%h exp=0", obs());
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_stream("rst_restart", 18, 0, 0, 0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_stream18();
        test_busy_protect();
        test_len0();
        test_start_with_load();
        test_abort_rst();
        test_len40();
        test_back_to_back();
        test_abort_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
